// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the IF/LS memory port arbiter.
package arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int MEM_AW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory signal bundle; the arbiter uses the slave modport,
// the requesters/memory environment uses the master modport.
interface mem_port_arbiter_if
    import arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MEM_AW = MEM_AW_DEF
);
    // Handshake: a requester holds req/addr/we/wdata stable until gnt is high
    // on a clock edge; that edge transfers the request. rvalid is a one-cycle
    // response pulse and rdata is only meaningful while rvalid is high.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_perf.sv
// Grant and stall event counters for the arbiter (built only with ARB_PERF_CNT_EN).
module arb_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic        ls_req_i,
    input  logic        if_gnt_i,
    input  logic        ls_gnt_i,
    output logic [31:0] perf_if_cnt_o,
    output logic [31:0] perf_ls_cnt_o,
    output logic [31:0] perf_stall_cnt_o
);
    logic [31:0] if_cnt_q, ls_cnt_q, stall_cnt_q;
    logic        stall;

    // A cycle stalls when any requester is asking and is not the one granted.
    assign stall = (if_req_i && !if_gnt_i) || (ls_req_i && !ls_gnt_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            if_cnt_q    <= '0;
            ls_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (if_gnt_i) if_cnt_q    <= if_cnt_q + 32'd1;
            if (ls_gnt_i) ls_cnt_q    <= ls_cnt_q + 32'd1;
            if (stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_if_cnt_o    = if_cnt_q;
    assign perf_ls_cnt_o    = ls_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between fetch (IF) and load/store (LS).
// Optional perf counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output arb_state_e          dbg_state_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_if_cnt,
    output logic [31:0]         perf_ls_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);
    arb_state_e        state_q, state_d;
    req_id_e           last_win_q, last_win_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic              if_gnt, ls_gnt, busy;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[ADDR_W-1:MEM_AW+2], bus.if_addr[1:0],
                                bus.ls_addr[ADDR_W-1:MEM_AW+2], bus.ls_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_win_q  <= REQ_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_win_q  <= last_win_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_win_d  = last_win_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The round-robin pointer only moves when both sides competed.
                if (bus.if_req && bus.ls_req)
                    last_win_d = ls_gnt ? REQ_LS : REQ_IF;
                if (if_gnt) begin
                    state_d = BUSY_IF;
                    addr_d  = bus.if_addr[MEM_AW+1:2];
                    we_d    = 1'b0;
                    wdata_d = '0;
                end else if (ls_gnt) begin
                    state_d = BUSY_LS;
                    addr_d  = bus.ls_addr[MEM_AW+1:2];
                    we_d    = bus.ls_we;
                    wdata_d = bus.ls_wdata;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ready) begin
                    state_d     = IDLE;
                    rdata_d     = bus.mem_rdata;
                    if_rvalid_d = 1'b1;
                end
            end
            BUSY_LS: begin
                if (bus.mem_ready) begin
                    state_d     = IDLE;
                    rdata_d     = we_q ? '0 : bus.mem_rdata;
                    ls_rvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (state_q == IDLE) begin
            if (bus.if_req && bus.ls_req) begin
                if (last_win_q == REQ_IF) ls_gnt = 1'b1;
                else                      if_gnt = 1'b1;
            end else begin
                if_gnt = bus.if_req;
                ls_gnt = bus.ls_req;
            end
        end
        busy          = (state_q != IDLE);
        bus.if_gnt    = if_gnt;
        bus.ls_gnt    = ls_gnt;
        bus.mem_req   = busy;
        bus.mem_we    = (state_q == BUSY_LS) && we_q;
        bus.mem_addr  = busy ? addr_q : '0;
        bus.mem_wdata = busy ? wdata_q : '0;
        bus.if_rvalid = if_rvalid_q;
        bus.ls_rvalid = ls_rvalid_q;
        bus.if_rdata  = if_rvalid_q ? rdata_q : '0;
        bus.ls_rdata  = ls_rvalid_q ? rdata_q : '0;
        dbg_state_o   = state_q;
    end

`ifdef ARB_PERF_CNT_EN
    arb_perf_counters u_perf (
        .clk              (clk),
        .rst              (rst),
        .if_req_i         (bus.if_req),
        .ls_req_i         (bus.ls_req),
        .if_gnt_i         (if_gnt),
        .ls_gnt_i         (ls_gnt),
        .perf_if_cnt_o    (perf_if_cnt),
        .perf_ls_cnt_o    (perf_ls_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
    );
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner
// sequences and randomized traffic against a transaction-level reference.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MEM_AW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) bus ();
    arb_state_e dbg_state;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_cnt, perf_ls_cnt, perf_stall_cnt;
`endif

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_cnt    (perf_if_cnt),
        .perf_ls_cnt    (perf_ls_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- requester drivers ----------------
    logic        if_pend, ls_pend, ls_we_r;
    logic [31:0] if_addr_r, ls_addr_r, ls_wdata_r;
    int          if_left, ls_left;
    bit          rand_mode;

    // ---------------- memory device ----------------
    logic [31:0] mem_arr[16];
    int          wcnt, cur_w, w_min, w_max;
    bit          idle_noise;

    // ---------------- reference model / scoreboard ----------------
    bit          m_busy;
    int          m_owner;  // 0 = IF, 1 = LS
    int          m_last;   // last contention winner, 0 = IF
    logic [3:0]  m_addr;
    bit          m_we;
    logic [31:0] m_wdata;
    bit          exp_if_rv, exp_ls_rv;
    logic [DATA_W-1:0] exp_if_q[$];
    logic [DATA_W-1:0] exp_ls_q[$];
    logic [31:0] ref_mem[16];
    int          m_if_cnt, m_ls_cnt, m_stall;

    int          gnt_log[$];
    logic [31:0] if_got, ls_got;
    int          cyc, if_gnt_cyc, if_rv_cyc, ls_gnt_cyc, ls_rv_cyc, memreq_cnt;

    task automatic set_wait(input int lo, input int hi);
        w_min = lo;
        w_max = hi;
        cur_w = $urandom_range(hi, lo);
        wcnt  = 0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_last = 0; exp_if_rv = 0; exp_ls_rv = 0;
        exp_if_q.delete(); exp_ls_q.delete(); gnt_log.delete();
        m_if_cnt = 0; m_ls_cnt = 0; m_stall = 0;
        if_pend = 0; ls_pend = 0; if_left = 0; ls_left = 0;
        wcnt = 0;
    endtask

    // One-cycle reset pulse, then the reset-state outputs are checked.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.if_req = 0; bus.ls_req = 0; bus.mem_ready = 0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst mem_req",   32'(bus.mem_req), 0);
        chk("rst mem_we",    32'(bus.mem_we), 0);
        chk("rst mem_addr",  32'(bus.mem_addr), 0);
        chk("rst mem_wdata", bus.mem_wdata, 0);
        chk("rst if_rvalid", 32'(bus.if_rvalid), 0);
        chk("rst ls_rvalid", 32'(bus.ls_rvalid), 0);
        chk("rst if_rdata",  bus.if_rdata, 0);
        chk("rst ls_rdata",  bus.ls_rdata, 0);
        chk("rst state",     32'(dbg_state), 32'(IDLE));
`ifdef ARB_PERF_CNT_EN
        chk("rst perf_if",    perf_if_cnt, 0);
        chk("rst perf_ls",    perf_ls_cnt, 0);
        chk("rst perf_stall", perf_stall_cnt, 0);
`endif
        rst = 1'b0;
    endtask

    // Drive inputs at negedge, sample 1ns later, then advance the model.
    task automatic cycle();
        bit e_if, e_ls;
        @(negedge clk);
        cyc++;
        if (rand_mode) begin
            if (!if_pend && $urandom_range(2, 0) != 0) begin
                if_pend = 1; if_addr_r = $urandom;
            end
            if (!ls_pend && $urandom_range(2, 0) != 0) begin
                ls_pend = 1; ls_addr_r = $urandom; ls_wdata_r = $urandom;
                ls_we_r = 1'($urandom_range(1, 0));
            end
        end else begin
            if (!if_pend && if_left > 0) begin
                if_pend = 1; if_left--; if_addr_r = $urandom;
            end
            if (!ls_pend && ls_left > 0) begin
                ls_pend = 1; ls_left--; ls_addr_r = $urandom; ls_wdata_r = $urandom;
                ls_we_r = 1'($urandom_range(1, 0));
            end
        end
        bus.if_req = if_pend;  bus.if_addr = if_addr_r;
        bus.ls_req = ls_pend;  bus.ls_addr = ls_addr_r;
        bus.ls_we  = ls_we_r;  bus.ls_wdata = ls_wdata_r;
        if (bus.mem_req) begin
            memreq_cnt++;
            if (wcnt >= cur_w) begin
                bus.mem_ready = 1'b1;
                wcnt  = 0;
                cur_w = $urandom_range(w_max, w_min);
            end else begin
                bus.mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            bus.mem_ready = idle_noise ? 1'($urandom_range(1, 0)) : 1'b0;
        end
        bus.mem_rdata = mem_arr[bus.mem_addr];
        #1;
        chk("mem_req", 32'(bus.mem_req), 32'(m_busy));
        if (m_busy) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            chk("mem_we", 32'(bus.mem_we), 32'(m_we));
            if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
        end
        chk("if_rvalid", 32'(bus.if_rvalid), 32'(exp_if_rv));
        if (bus.if_rvalid) begin
            if_got = bus.if_rdata; if_rv_cyc = cyc;
            if (exp_if_q.size() > 0) chk("if_rdata", bus.if_rdata, exp_if_q.pop_front());
        end
        chk("ls_rvalid", 32'(bus.ls_rvalid), 32'(exp_ls_rv));
        if (bus.ls_rvalid) begin
            ls_got = bus.ls_rdata; ls_rv_cyc = cyc;
            if (exp_ls_q.size() > 0) chk("ls_rdata", bus.ls_rdata, exp_ls_q.pop_front());
        end
        e_if = 0; e_ls = 0;
        if (!m_busy) begin
            if (if_pend && ls_pend) begin
                if (m_last == 0) e_ls = 1; else e_if = 1;
                m_last = e_if ? 0 : 1;
            end else begin
                e_if = if_pend; e_ls = ls_pend;
            end
        end
        chk("if_gnt", 32'(bus.if_gnt), 32'(e_if));
        chk("ls_gnt", 32'(bus.ls_gnt), 32'(e_ls));
        if ((if_pend && !e_if) || (ls_pend && !e_ls)) m_stall++;
        if (bus.mem_req && bus.mem_ready && bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
        exp_if_rv = 0; exp_ls_rv = 0;
        if (m_busy && bus.mem_ready) begin
            if (m_owner == 0) exp_if_rv = 1; else exp_ls_rv = 1;
            m_busy = 0;
        end
        if (e_if) begin
            m_busy = 1; m_owner = 0; m_addr = if_addr_r[5:2]; m_we = 0;
            exp_if_q.push_back(ref_mem[m_addr]);
            if_pend = 0; gnt_log.push_back(0); if_gnt_cyc = cyc; m_if_cnt++;
        end else if (e_ls) begin
            m_busy = 1; m_owner = 1; m_addr = ls_addr_r[5:2]; m_we = ls_we_r; m_wdata = ls_wdata_r;
            if (ls_we_r) begin
                ref_mem[m_addr] = ls_wdata_r;
                exp_ls_q.push_back('0);
            end else begin
                exp_ls_q.push_back(ref_mem[m_addr]);
            end
            ls_pend = 0; gnt_log.push_back(1); ls_gnt_cyc = cyc; m_ls_cnt++;
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while ((if_pend || ls_pend || if_left > 0 || ls_left > 0 || m_busy ||
                    exp_if_q.size() > 0 || exp_ls_q.size() > 0) && n < budget);
        chk("drain timeout", 32'(m_busy || if_pend || ls_pend || exp_if_q.size() > 0 ||
                                 exp_ls_q.size() > 0), 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          if_req, ls_req, ls_we;
        logic [31:0] if_addr, ls_addr, wdata;
        int          first;
        logic [31:0] exp_if, exp_ls;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem_arr[i] = 32'h1000_0000 + 32'(i);
        mem_arr[2] = 32'h4012_02B3;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem_arr[i];
        rand_mode = 0; idle_noise = 0; cyc = 0; memreq_cnt = 0;
        if_addr_r = 0; ls_addr_r = 0; ls_wdata_r = 0; ls_we_r = 0;
        bus.if_req = 0; bus.ls_req = 0; bus.ls_we = 0; bus.if_addr = 0;
        bus.ls_addr = 0; bus.ls_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
        set_wait(0, 0);

        vecs[0] = '{1, 0, 0, 32'h08, 32'h00, 32'h0, 0, 32'h4012_02B3, 32'h0};
        vecs[1] = '{0, 1, 1, 32'h00, 32'h04, 32'hDEAD_BEEF, 1, 32'h0, 32'h0};
        vecs[2] = '{0, 1, 0, 32'h00, 32'h04, 32'h0, 1, 32'h0, 32'hDEAD_BEEF};
        vecs[3] = '{1, 1, 0, 32'h04, 32'h0C, 32'h0, 1, 32'hDEAD_BEEF, 32'h1000_0003};
        vecs[4] = '{1, 1, 1, 32'h43, 32'hFFFF_FFF8, 32'h1234_5678, 0, 32'h1000_0000, 32'h0};
        vecs[5] = '{1, 1, 0, 32'h3C, 32'h38, 32'h0, 1, 32'h1000_000F, 32'h1234_5678};

        do_reset();

        for (int i = 0; i < 6; i++) begin
            if_pend = vecs[i].if_req; if_addr_r = vecs[i].if_addr;
            ls_pend = vecs[i].ls_req; ls_addr_r = vecs[i].ls_addr;
            ls_we_r = vecs[i].ls_we;  ls_wdata_r = vecs[i].wdata;
            gnt_log.delete();
            if_got = 32'h0BAD_0BAD; ls_got = 32'h0BAD_0BAD;
            run_until_idle(40);
            chk("vec first grant", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 32'(vecs[i].first));
            chk("vec latency", 32'(vecs[i].first == 0 ? if_rv_cyc - if_gnt_cyc : ls_rv_cyc - ls_gnt_cyc), 2);
            if (vecs[i].if_req) chk("vec if_rdata", if_got, vecs[i].exp_if);
            if (vecs[i].ls_req) chk("vec ls_rdata", ls_got, vecs[i].exp_ls);
        end

        // Wait states: LS load with W=3, IF arrives while LS is in flight.
        set_wait(3, 3);
        memreq_cnt = 0;
        ls_pend = 1; ls_we_r = 0; ls_addr_r = 32'h10;
        cycle();
        if_pend = 1; if_addr_r = 32'h14;
        run_until_idle(40);
        chk("wait ls latency", 32'(ls_rv_cyc - ls_gnt_cyc), 5);
        chk("wait if gnt at rvalid", 32'(if_gnt_cyc), 32'(ls_rv_cyc));
        chk("wait mem_req cycles", 32'(memreq_cnt), 8);
        chk("wait ls_rdata", ls_got, 32'h1000_0004);
        chk("wait if_rdata", if_got, 32'h1000_0005);

        // Reset while an LS load is stuck in BUSY_LS.
        set_wait(20, 20);
        ls_pend = 1; ls_we_r = 0; ls_addr_r = 32'h20;
        repeat (3) cycle();
        chk("abort state busy_ls", 32'(dbg_state), 32'(BUSY_LS));
        do_reset();
        ls_rv_cyc = -1;
        set_wait(0, 0);
        repeat (10) cycle();
        chk("abort no rvalid", 32'(ls_rv_cyc), 32'hFFFF_FFFF);

        // Four back-to-back contended transactions after reset.
        if_left = 2; ls_left = 2;
        run_until_idle(60);
        chk("contend count", 32'(gnt_log.size()), 4);
        for (int i = 0; i < 4; i++)
            chk("contend order", 32'(i < gnt_log.size() ? gnt_log[i] : -1), 32'((i % 2 == 0) ? 1 : 0));
        chk("contend stall model", 32'(m_stall), 6);
`ifdef ARB_PERF_CNT_EN
        chk("perf_if_cnt", perf_if_cnt, 2);
        chk("perf_ls_cnt", perf_ls_cnt, 2);
        chk("perf_stall_cnt", perf_stall_cnt, 6);
`endif

        // Randomized traffic with random wait states and idle mem_ready noise.
        set_wait(0, 2);
        idle_noise = 1;
        rand_mode = 1;
        repeat (400) cycle();
        rand_mode = 0;
        run_until_idle(100);
`ifdef ARB_PERF_CNT_EN
        chk("rand perf_if_cnt", perf_if_cnt, 32'(m_if_cnt));
        chk("rand perf_ls_cnt", perf_ls_cnt, 32'(m_ls_cnt));
        chk("rand perf_stall_cnt", perf_stall_cnt, 32'(m_stall));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
